// File: rtl/ej32_pkg.sv
// ej32_pkg: shared types for the ej32 core slice
package ej32_pkg;
   typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_st_t;
   typedef enum logic [1:0] {SO_NONE, SO_PUSH, SO_POP, SO_REPL} stack_op;
   typedef enum logic [7:0] {
      OP_NOP  = 8'h00,
      OP_IADD = 8'h60,
      OP_ISUB = 8'h64,
      OP_IMUL = 8'h68,
      OP_IDIV = 8'h6c,
      OP_IREM = 8'h70
   } opcode_t;
endpackage

// File: rtl/ej32_neg.sv
// ej32_neg: conditional two's-complement negate
module ej32_neg #(
   parameter int DSZ = 32
) (
   input  logic           neg,
   input  logic [DSZ-1:0] a,
   output logic [DSZ-1:0] y
);
   assign y = neg ? -a : a;
endmodule

// File: rtl/ej32_div.sv
// ej32_div: multi-cycle restoring divider, Java idiv/irem or unsigned
module ej32_div
   import ej32_pkg::*;
#(
   parameter int DSZ = 32
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           div_en,
   input  logic           sgn,
   input  logic [DSZ-1:0] s,
   input  logic [DSZ-1:0] t,
   output logic           div_bsy,
   output logic           div_done,
   output logic [DSZ-1:0] div_q,
   output logic [DSZ-1:0] div_r,
   output logic           div_z
);
   localparam int CW = $clog2(DSZ);
   div_st_t st, st_nxt;
   logic [CW-1:0] cnt;
   logic [DSZ-1:0] s_r, t_r, dm, quo, rem, s_abs, t_abs, q_fix, r_fix;
   logic qs, rs, start;
   logic [DSZ:0] sh, diff;
   ej32_neg #(.DSZ(DSZ)) u_abs_s (.neg(s[DSZ-1] & sgn), .a(s), .y(s_abs));
   ej32_neg #(.DSZ(DSZ)) u_abs_t (.neg(t[DSZ-1] & sgn), .a(t), .y(t_abs));
   ej32_neg #(.DSZ(DSZ)) u_fix_q (.neg(qs), .a(quo), .y(q_fix));
   ej32_neg #(.DSZ(DSZ)) u_fix_r (.neg(rs), .a(rem), .y(r_fix));
   always_comb begin
      start  = (st == IDLE || st == DONE) && div_en;
      sh     = {rem, quo[DSZ-1]};
      diff   = sh - {1'b0, dm};
      st_nxt = start ? CALC :
               st == CALC ? (cnt == '0 ? FIX : CALC) :
               st == FIX  ? DONE : IDLE;
   end
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= IDLE;
         cnt      <= '0;
         div_bsy  <= 1'b0;
         div_done <= 1'b0;
         div_q    <= '0;
         div_r    <= '0;
         div_z    <= 1'b0;
         s_r      <= '0;
         t_r      <= '0;
         dm       <= '0;
         quo      <= '0;
         rem      <= '0;
         qs       <= 1'b0;
         rs       <= 1'b0;
      end else begin
         st       <= st_nxt;
         div_bsy  <= st_nxt == CALC || st_nxt == FIX;
         div_done <= st_nxt == DONE;
         if (start) begin
            s_r <= s;
            t_r <= t;
            dm  <= t_abs;
            quo <= s_abs;
            rem <= '0;
            qs  <= (s[DSZ-1] ^ t[DSZ-1]) & sgn;
            rs  <= s[DSZ-1] & sgn;
            cnt <= CW'(DSZ - 1);
         end else if (st == CALC) begin
            // a set diff MSB means the trial subtract went negative: restore
            rem <= diff[DSZ] ? sh[DSZ-1:0] : diff[DSZ-1:0];
            quo <= {quo[DSZ-2:0], ~diff[DSZ]};
            cnt <= cnt - 1'b1;
         end else if (st == FIX) begin
            div_q <= t_r == '0 ? '0 : q_fix;
            div_r <= t_r == '0 ? s_r : r_fix;
            div_z <= t_r == '0;
         end
      end
   end
endmodule

// File: tb/tb_ej32_div.sv
// tb_ej32_div: vector table plus scoreboard bench for ej32_div
module tb_ej32_div;
   logic clk = 0, rst = 1, div_en = 0, sgn = 0;
   logic [31:0] s = 0, t = 0;
   logic div_bsy, div_done, div_z;
   logic [31:0] div_q, div_r;
   int n_chk = 0, n_fail = 0;

   typedef struct {logic sg; logic [31:0] s, t, q, r; logic z;} vec_t;
   typedef struct {logic [31:0] q, r; logic z;} exp_t;
   exp_t sb[$];
   vec_t vt[12];

   ej32_div #(.DSZ(32)) dut (
      .clk(clk), .rst(rst), .div_en(div_en), .sgn(sgn), .s(s), .t(t),
      .div_bsy(div_bsy), .div_done(div_done), .div_q(div_q), .div_r(div_r), .div_z(div_z)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic check_result(input string tag);
      exp_t e;
      n_chk++;
      if (sb.size() == 0) begin
         n_fail++;
         $display("FAIL %s: scoreboard empty at div_done", tag);
      end else begin
         e = sb.pop_front();
         check({tag, " q"}, div_q, e.q);
         check({tag, " r"}, div_r, e.r);
         check({tag, " z"}, 32'(div_z), 32'(e.z));
      end
   endtask

   // one division; pulse_at>0 raises a stray div_en during CALC
   task automatic run_one(input vec_t v, input int pulse_at, input string tag);
      exp_t e;
      int n, nb;
      e.q = v.q; e.r = v.r; e.z = v.z;
      sb.push_back(e);
      @(negedge clk);
      sgn = v.sg; s = v.s; t = v.t; div_en = 1;
      n = 0; nb = 0;
      do begin
         @(negedge clk);
         n++;
         div_en = (n == pulse_at);
         s = $urandom; t = $urandom; sgn = 1'($urandom);
         if (div_bsy) nb++;
      end while (!div_done && n < 60);
      check({tag, " latency"}, n, 34);
      check({tag, " bsy cycles"}, nb, 33);
      check_result(tag);
   endtask

   initial begin
      vt[0]  = '{1, 32'd100,       32'd7,          32'd14,         32'd2,          0};
      vt[1]  = '{1, -32'sd100,     32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   0};
      vt[2]  = '{1, 32'd100,       -32'sd7,        32'hFFFFFFF2,   32'd2,          0};
      vt[3]  = '{1, 32'h80000000,  32'hFFFFFFFF,   32'h80000000,   32'd0,          0};
      vt[4]  = '{0, 32'h80000000,  32'hFFFFFFFF,   32'd0,          32'h80000000,   0};
      vt[5]  = '{1, 32'h1234,      32'd0,          32'd0,          32'h1234,       1};
      vt[6]  = '{0, 32'hFFFFFFFF,  32'd3,          32'h55555555,   32'd0,          0};
      vt[7]  = '{0, 32'd7,         32'hFFFFFFFF,   32'd0,          32'd7,          0};
      vt[8]  = '{1, -32'sd7,       -32'sd2,        32'd3,          32'hFFFFFFFF,   0};
      vt[9]  = '{1, -32'sd100,     32'd0,          32'd0,          32'hFFFFFF9C,   1};
      vt[10] = '{1, 32'd0,         32'd5,          32'd0,          32'd0,          0};
      vt[11] = '{0, 32'hFFFFFFFF,  32'hFFFFFFFF,   32'd1,          32'd0,          0};

      #1;
      check("reset bsy", 32'(div_bsy), 0);
      check("reset done", 32'(div_done), 0);
      check("reset q", div_q, 0);
      check("reset r", div_r, 0);
      check("reset z", 32'(div_z), 0);
      repeat (2) @(negedge clk);
      rst = 0;

      for (int i = 0; i < 12; i++) run_one(vt[i], 0, $sformatf("vec%0d", i));

      // asynchronous reset in the middle of CALC; last result is nonzero
      @(negedge clk);
      sgn = 1; s = 32'd100; t = 32'd7; div_en = 1;
      @(negedge clk);
      div_en = 0;
      repeat (9) @(negedge clk);
      check("pre-abort bsy", 32'(div_bsy), 1);
      rst = 1;
      #1;
      check("abort bsy", 32'(div_bsy), 0);
      check("abort done", 32'(div_done), 0);
      check("abort q", div_q, 0);
      check("abort r", div_r, 0);
      check("abort z", 32'(div_z), 0);
      @(negedge clk);
      rst = 0;
      run_one('{1, 32'd9, 32'd3, 32'd3, 32'd0, 0}, 0, "post-reset");

      // stray div_en pulses during CALC are dropped, nothing queued
      run_one('{1, 32'd1000, 32'd9, 32'd111, 32'd1, 0}, 5, "ignore");
      @(negedge clk);
      check("no queued bsy", 32'(div_bsy), 0);
      check("no queued done", 32'(div_done), 0);

      // div_en held high: a start is taken in every DONE
      for (int k = 0; k < 3; k++) sb.push_back('{32'd8, 32'd2, 1'b0});
      @(negedge clk);
      sgn = 0; s = 32'd50; t = 32'd6; div_en = 1;
      for (int k = 0; k < 3; k++) begin
         int n;
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!div_done && n < 60);
         check($sformatf("b2b period %0d", k), n, 34);
         check_result($sformatf("b2b%0d", k));
      end
      div_en = 0;
      @(negedge clk);
      check("b2b stop done", 32'(div_done), 0);
      check("b2b stop bsy", 32'(div_bsy), 0);
      check("scoreboard drained", sb.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
